// File: rtl/parking_status_tx.sv
// parking_status_tx: formats parking-controller status snapshots as ASCII lines
// and streams them over a valid/ready byte interface. Optional: PARKING_TX_CHECKSUM_EN.
module parking_status_tx #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned HEARTBEAT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] parking_slots,
    input  logic [2:0] capacity,
    input  logic [2:0] best_place,
    input  logic       door_open_light,
    input  logic       full_light,
    input  logic       report_req,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

`ifdef PARKING_TX_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd16;
`else
    localparam logic [4:0] LAST_IDX = 5'd13;
`endif

    // Snapshot layout: [11:8] slots, [7:5] capacity, [4:2] best_place, [1] door, [0] full
    function automatic logic [7:0] base_byte(input logic [11:0] s, input logic [4:0] i);
        logic [7:0] b;
        b = 8'h0A;
        case (i)
            5'd0:    b = s[11] ? 8'h31 : 8'h30;
            5'd1:    b = s[10] ? 8'h31 : 8'h30;
            5'd2:    b = s[9]  ? 8'h31 : 8'h30;
            5'd3:    b = s[8]  ? 8'h31 : 8'h30;
            5'd4:    b = 8'h20;
            5'd5:    b = 8'h5B;
            5'd6:    b = 8'h30 + {5'b0, s[7:5]};
            5'd7:    b = 8'h2C;
            5'd8:    b = 8'h30 + {5'b0, s[4:2]};
            5'd9:    b = 8'h5D;
            5'd10:   b = 8'h20;
            5'd11:   b = s[1] ? 8'h4F : 8'h2D;
            5'd12:   b = s[0] ? 8'h46 : 8'h2D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

`ifdef PARKING_TX_CHECKSUM_EN
    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [11:0] s, input logic [4:0] i);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        for (int unsigned j = 0; j < 13; j++) begin
            x = x ^ base_byte(s, 5'(j));
        end
        case (i)
            5'd13:   b = 8'h2A;
            5'd14:   b = hex_digit(x[7:4]);
            5'd15:   b = hex_digit(x[3:0]);
            5'd16:   b = 8'h0A;
            default: b = base_byte(s, i);
        endcase
        return b;
    endfunction
`else
    function automatic logic [7:0] frame_byte(input logic [11:0] s, input logic [4:0] i);
        return base_byte(s, i);
    endfunction
`endif

    state_t      state;
    logic [4:0]  idx;
    logic [11:0] sent_snap;
    logic        first;
    logic        pending;
    logic [31:0] gap_cnt;
    logic [31:0] hb_cnt;
    logic [11:0] snap;
    logic        change;
    logic        hb_expire;

    assign snap      = {parking_slots, capacity, best_place, door_open_light, full_light};
    // One register serves as both the in-flight frame and the last-sent snapshot:
    // both are written only in LOAD, so they always hold the same value.
    assign change    = (snap != sent_snap);
    assign hb_expire = (HEARTBEAT != 0) && (hb_cnt == 32'(HEARTBEAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            sent_snap   <= '0;
            first       <= 1'b1;
            pending     <= 1'b0;
            gap_cnt     <= '0;
            hb_cnt      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (first || pending || change || report_req || hb_expire) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else if (HEARTBEAT != 0) begin
                        hb_cnt <= hb_cnt + 32'd1;
                    end
                end
                LOAD: begin
                    sent_snap <= snap;
                    first     <= 1'b0;
                    pending   <= 1'b0;
                    idx       <= '0;
                    hb_cnt    <= '0;
                    tx_data   <= frame_byte(snap, 5'd0);
                    tx_valid  <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (change || report_req) pending <= 1'b1;
                    if (tx_ready) begin
                        if (idx == LAST_IDX) begin
                            tx_valid    <= 1'b0;
                            frames_sent <= frames_sent + 8'd1;
                            gap_cnt     <= '0;
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            idx     <= idx + 5'd1;
                            tx_data <= frame_byte(sent_snap, idx + 5'd1);
                        end
                    end
                end
                GAP: begin
                    if (change || report_req) pending <= 1'b1;
                    if (gap_cnt == 32'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
